// File: rtl/raytrace_result_writer.sv
// Captures finished ray-tracing jobs from one worker into a 2-entry queue and
// serializes them as framebuffer pixel writes over a valid/ready port.
module raytrace_result_writer #(
  parameter int N_WORKERS        = 4,
  parameter int JOBS_SUBDIVISION = 8,
  parameter int COLOR_B          = 12,
  parameter int FB_W             = 640,
  parameter int FB_H             = 480,
  parameter int ADDR_B           = 19
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_worker_busy,
  input  logic [JOBS_SUBDIVISION*COLOR_B-1:0] i_worker_buffer,
  input  logic signed [11:0]                  i_job_start_x,
  input  logic signed [11:0]                  i_job_y,
  output logic                                o_queue_ready,
  output logic                                o_fb_valid,
  output logic [ADDR_B-1:0]                   o_fb_addr,
  output logic [COLOR_B-1:0]                  o_fb_data,
  input  logic                                i_fb_ready,
  output logic                                o_overflow,
  output logic [7:0]                          o_drop_count
);

  localparam int BUF_B = JOBS_SUBDIVISION * COLOR_B;
  localparam int K_B   = (JOBS_SUBDIVISION > 1) ? $clog2(JOBS_SUBDIVISION) : 1;
  localparam logic [K_B-1:0]   K_LAST = K_B'(JOBS_SUBDIVISION - 1);
  localparam logic signed [12:0] X_OFS = 13'(FB_W / 2);
  localparam logic signed [12:0] Y_OFS = 13'(FB_H / 2 - 1);
  localparam logic signed [12:0] W_S   = 13'(FB_W);
  localparam logic signed [12:0] H_S   = 13'(FB_H);

  typedef enum logic {S_IDLE = 1'b0, S_EMIT = 1'b1} state_t;

  logic [BUF_B-1:0]    r_q_colors [2];
  logic signed [12:0]  r_q_x0     [2];
  logic signed [12:0]  r_q_y      [2];
  logic                r_wr_ptr, r_rd_ptr, r_busy_q, r_overflow;
  logic [1:0]          r_count;
  state_t              r_state, w_next_state;
  logic [K_B-1:0]      r_k, w_next_k;
  logic                r_fb_valid;
  logic [ADDR_B-1:0]   r_fb_addr;
  logic [COLOR_B-1:0]  r_fb_data;
  logic [7:0]          r_drop_count;

  logic                w_capture, w_push, w_pop, w_load, w_drop, w_adv;
  logic signed [12:0]  w_cap_x0, w_cap_y, w_sel_x0, w_sel_y;
  logic [BUF_B-1:0]    w_sel_colors;
  logic [ADDR_B+COLOR_B:0] w_beat;

  // Returns {on_screen, addr, color} for pixel k of a job already mapped to screen space.
  function automatic logic [ADDR_B+COLOR_B:0] pixel_beat(
    input logic [BUF_B-1:0]   colors,
    input logic signed [12:0] x0,
    input logic signed [12:0] y,
    input logic [K_B-1:0]     k
  );
    logic signed [12:0] x;
    logic               on;
    logic [ADDR_B-1:0]  addr;
    x    = x0 + $signed(13'(k) * 13'(N_WORKERS));
    on   = (x >= 13'sd0) && (x < W_S) && (y >= 13'sd0) && (y < H_S);
    addr = ADDR_B'($unsigned(y)) * ADDR_B'(FB_W) + ADDR_B'($unsigned(x));
    return {on, addr, colors[int'(k)*COLOR_B +: COLOR_B]};
  endfunction

  assign w_capture = r_busy_q && !i_worker_busy;
  assign w_push    = w_capture && (r_count != 2'd2);
  assign w_cap_x0  = $signed({i_job_start_x[11], i_job_start_x}) + X_OFS;
  assign w_cap_y   = Y_OFS - $signed({i_job_y[11], i_job_y});

  // Next pixel selection; on the final pixel the next job comes from the other slot or the bypassed capture.
  always_comb begin
    w_next_state = r_state;
    w_next_k     = r_k;
    w_load       = 1'b0;
    w_pop        = 1'b0;
    w_drop       = 1'b0;
    w_adv        = r_fb_valid ? i_fb_ready : 1'b1;
    w_sel_colors = r_q_colors[r_rd_ptr];
    w_sel_x0     = r_q_x0[r_rd_ptr];
    w_sel_y      = r_q_y[r_rd_ptr];
    case (r_state)
      S_IDLE: begin
        if (r_count != 2'd0) begin
          w_next_state = S_EMIT;
          w_next_k     = {K_B{1'b0}};
          w_load       = 1'b1;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_EMIT: begin
        if (w_adv) begin
          w_drop = !r_fb_valid;
          if (r_k == K_LAST) begin
            w_pop    = 1'b1;
            w_next_k = {K_B{1'b0}};
            if (r_count == 2'd2) begin
              w_sel_colors = r_q_colors[~r_rd_ptr];
              w_sel_x0     = r_q_x0[~r_rd_ptr];
              w_sel_y      = r_q_y[~r_rd_ptr];
              w_load       = 1'b1;
            end else if (w_push) begin
              w_sel_colors = i_worker_buffer;
              w_sel_x0     = w_cap_x0;
              w_sel_y      = w_cap_y;
              w_load       = 1'b1;
            end else begin
              w_next_state = S_IDLE;
            end
          end else begin
            w_next_k = r_k + K_B'(1);
            w_load   = 1'b1;
          end
        end else begin
          w_next_state = S_EMIT;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
    w_beat = pixel_beat(w_sel_colors, w_sel_x0, w_sel_y, w_next_k);
  end

  // Busy edge detect, queue pointers/occupancy and sticky overflow.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy_q   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_overflow <= 1'b0;
    end else begin
      r_busy_q <= i_worker_busy;
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      if (w_capture && !w_push) r_overflow <= 1'b1;
    end
  end

  // Queue storage holds screen-space coordinates so mapping happens once per job.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_q_colors[r_wr_ptr] <= i_worker_buffer;
      r_q_x0[r_wr_ptr]     <= w_cap_x0;
      r_q_y[r_wr_ptr]      <= w_cap_y;
    end
  end

  // FSM state, registered write port and saturating drop counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_k          <= {K_B{1'b0}};
      r_fb_valid   <= 1'b0;
      r_fb_addr    <= {ADDR_B{1'b0}};
      r_fb_data    <= {COLOR_B{1'b0}};
      r_drop_count <= 8'd0;
    end else begin
      r_state <= w_next_state;
      r_k     <= w_next_k;
      if (w_load) begin
        {r_fb_valid, r_fb_addr, r_fb_data} <= w_beat;
      end else if (w_pop) begin
        r_fb_valid <= 1'b0;
      end
      if (w_drop && (r_drop_count != 8'hFF)) r_drop_count <= r_drop_count + 8'd1;
    end
  end

  assign o_queue_ready = (r_count != 2'd2);
  assign o_fb_valid    = r_fb_valid;
  assign o_fb_addr     = r_fb_addr;
  assign o_fb_data     = r_fb_data;
  assign o_overflow    = r_overflow;
  assign o_drop_count  = r_drop_count;

endmodule

// File: tb/tb_raytrace_result_writer.sv
// Scoreboard bench for raytrace_result_writer: a plain-arithmetic job model fills
// the expected-beat queue, and a forked monitor compares every handshake.
module tb_raytrace_result_writer;
  localparam int NW = 4, JS = 8, CB = 12, FBW = 640, FBH = 480, AB = 19;

  logic clk = 1'b0, rst = 1'b1, worker_busy = 1'b0, fb_ready = 1'b0;
  logic [JS*CB-1:0]  worker_buffer = '0;
  logic signed [11:0] job_start_x = 12'sd0, job_y = 12'sd0;
  logic              queue_ready, fb_valid, overflow;
  logic [AB-1:0]     fb_addr;
  logic [CB-1:0]     fb_data;
  logic [7:0]        drop_count;

  typedef struct packed {logic [AB-1:0] addr; logic [CB-1:0] data;} beat_t;
  beat_t sb[$];
  int checks = 0, errors = 0, beats = 0, exp_drop = 0, last_beats = 0, ready_mode = 1;
  int b0, b1;
  bit exp_ovf = 1'b0;

  always #5 clk = ~clk;

  raytrace_result_writer dut (
    .i_clk(clk), .i_rst(rst), .i_worker_busy(worker_busy), .i_worker_buffer(worker_buffer),
    .i_job_start_x(job_start_x), .i_job_y(job_y), .o_queue_ready(queue_ready),
    .o_fb_valid(fb_valid), .o_fb_addr(fb_addr), .o_fb_data(fb_data), .i_fb_ready(fb_ready),
    .o_overflow(overflow), .o_drop_count(drop_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [JS*CB-1:0] seq_colors(input int start);
    logic [JS*CB-1:0] c;
    for (int k = 0; k < JS; k++) c[k*CB +: CB] = CB'(start + k);
    return c;
  endfunction

  // Reference model: map the job to the screen and list the beats it should produce.
  task automatic expect_job(input int sx, input int y, input logic [JS*CB-1:0] colors);
    int x0, sy, x;
    beat_t b;
    x0 = sx + FBW / 2;
    sy = FBH / 2 - 1 - y;
    last_beats = 0;
    for (int k = 0; k < JS; k++) begin
      x = x0 + k * NW;
      if (x >= 0 && x < FBW && sy >= 0 && sy < FBH) begin
        b.addr = AB'(sy * FBW + x);
        b.data = colors[k*CB +: CB];
        sb.push_back(b);
        last_beats++;
      end else if (exp_drop < 255) begin
        exp_drop++;
      end
    end
  endtask

  // Returns in the capture cycle (busy_q=1, busy=0).
  task automatic capture(input int sx, input int y, input logic [JS*CB-1:0] colors, input bit accepted);
    tick();
    worker_busy   = 1'b1;
    job_start_x   = 12'(sx);
    job_y         = 12'(y);
    worker_buffer = colors;
    tick();
    worker_busy = 1'b0;
    if (accepted) expect_job(sx, y, colors);
    else exp_ovf = 1'b1;
  endtask

  task automatic wait_sb(input int n);
    int cyc = 0;
    while (sb.size() > n && cyc < 4000) begin
      tick();
      cyc++;
    end
    chk("sb_level_reached", 32'(sb.size() <= n), 32'd1);
  endtask

  task automatic monitor();
    bit prev_stall = 1'b0;
    logic [AB-1:0] pa = '0;
    logic [CB-1:0] pd = '0;
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid_hold", 32'(fb_valid), 32'd1);
          chk("stall_addr_hold", 32'(fb_addr), 32'(pa));
          chk("stall_data_hold", 32'(fb_data), 32'(pd));
        end
        if (fb_valid && fb_ready) begin
          beats++;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got addr 0x%0h data 0x%0h, expected no beat", fb_addr, fb_data);
          end else begin
            e = sb.pop_front();
            chk("beat_addr", 32'(fb_addr), 32'(e.addr));
            chk("beat_data", 32'(fb_data), 32'(e.data));
          end
        end
        prev_stall = fb_valid && !fb_ready;
        pa = fb_addr;
        pd = fb_data;
      end
    end
  endtask

  task automatic ready_driver();
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: fb_ready = 1'b0;
        1: fb_ready = 1'b1;
        2: fb_ready = !fb_ready;
        default: fb_ready = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  initial begin
    fork
      monitor();
      ready_driver();
    join_none

    // Reset values, and no capture from a worker that is already idle.
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_queue_ready", 32'(queue_ready), 32'd1);
    chk("rst_fb_valid", 32'(fb_valid), 32'd0);
    chk("rst_fb_addr", 32'(fb_addr), 32'd0);
    chk("rst_fb_data", 32'(fb_data), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_drop_count", 32'(drop_count), 32'd0);
    tick();
    rst = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    chk("no_capture_after_reset", 32'(beats), 32'd0);
    chk("idle_fb_valid", 32'(fb_valid), 32'd0);

    // Top-left job: latency t+2, 8 consecutive beats.
    b0 = beats;
    capture(-320, 239, seq_colors(1), 1'b1);
    @(negedge clk); chk("lat_t0_valid", 32'(fb_valid), 32'd0);
    tick(); @(negedge clk); chk("lat_t1_valid", 32'(fb_valid), 32'd0);
    tick(); @(negedge clk); chk("lat_t2_valid", 32'(fb_valid), 32'd1);
    for (int i = 1; i < JS; i++) begin
      tick(); @(negedge clk); chk("burst_valid", 32'(fb_valid), 32'd1);
    end
    tick(); @(negedge clk); chk("burst_end_valid", 32'(fb_valid), 32'd0);
    wait_sb(0);
    chk("t1_beats", 32'(beats - b0), 32'd8);

    // Same job with fb_ready toggling.
    ready_mode = 2;
    b0 = beats;
    capture(-320, 239, seq_colors(1), 1'b1);
    wait_sb(0);
    repeat (4) tick();
    chk("t2_beats", 32'(beats - b0), 32'd8);
    ready_mode = 1;

    // Right edge: k=5..7 fall off-screen.
    capture(300, 0, seq_colors(12'h200), 1'b1);
    wait_sb(0);
    repeat (12) tick();
    chk("t3_drop_count", 32'(drop_count), 32'(exp_drop));
    chk("t3_model_drop", 32'(exp_drop), 32'd3);

    // Stalled sink: two queued, third overflows.
    ready_mode = 0;
    repeat (2) tick();
    b0 = beats;
    capture(-100, 50, seq_colors(12'h300), 1'b1);
    repeat (8) tick();
    capture(-200, -30, seq_colors(12'h400), 1'b1);
    tick(); @(negedge clk);
    chk("t4_queue_full", 32'(queue_ready), 32'd0);
    repeat (7) tick();
    capture(0, 0, seq_colors(12'h500), 1'b0);
    tick(); @(negedge clk);
    chk("t4_overflow", 32'(overflow), 32'(exp_ovf));
    chk("t4_no_beats_stalled", 32'(beats - b0), 32'd0);
    ready_mode = 1;
    wait_sb(0);
    repeat (12) tick();
    chk("t4_beats", 32'(beats - b0), 32'd16);
    chk("t4_queue_ready_after", 32'(queue_ready), 32'd1);

    // Capture lands on the last handshake of the only queued job.
    capture(-320, 100, seq_colors(12'h600), 1'b1);
    repeat (7) tick();
    capture(-160, -100, seq_colors(12'h700), 1'b1);
    @(negedge clk);
    chk("t5_last_beat_valid", 32'(fb_valid), 32'd1);
    tick(); @(negedge clk);
    chk("t5_b2b_valid", 32'(fb_valid), 32'd1);
    chk("t5_b2b_addr", 32'(fb_addr), 32'(339 * 640 + 160));
    chk("t5_queue_ready", 32'(queue_ready), 32'd1);
    wait_sb(0);

    // Randomized jobs and sink back-pressure, at most two jobs in flight.
    ready_mode = 3;
    for (int n = 0; n < 40; n++) begin
      wait_sb(last_beats);
      repeat (10 + $urandom_range(0, 3)) tick();
      capture(int'($urandom_range(0, 700)) - 350, int'($urandom_range(0, 520)) - 260,
              {$urandom, $urandom, $urandom}, 1'b1);
    end
    wait_sb(0);
    repeat (12) tick();
    chk("rand_drop_count", 32'(drop_count), 32'(exp_drop));
    chk("rand_overflow", 32'(overflow), 32'(exp_ovf));
    ready_mode = 1;
    repeat (2) tick();

    // Reset in the middle of a job.
    capture(-320, 10, seq_colors(12'h800), 1'b1);
    repeat (4) tick();
    @(negedge clk);
    chk("t6_mid_valid", 32'(fb_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    exp_drop = 0;
    exp_ovf  = 1'b0;
    @(negedge clk);
    chk("t6_fb_valid", 32'(fb_valid), 32'd0);
    chk("t6_queue_ready", 32'(queue_ready), 32'd1);
    chk("t6_fb_addr", 32'(fb_addr), 32'd0);
    chk("t6_overflow", 32'(overflow), 32'd0);
    chk("t6_drop_count", 32'(drop_count), 32'd0);
    b1 = beats;
    repeat (20) tick();
    chk("t6_no_beats", 32'(beats - b1), 32'd0);

    b1 = beats;
    capture(-320, 239, seq_colors(12'h900), 1'b1);
    wait_sb(0);
    repeat (12) tick();
    chk("post_rst_beats", 32'(beats - b1), 32'd8);
    chk("post_rst_drop", 32'(drop_count), 32'(exp_drop));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
